stage_sequencer: RTL and testbench

//  Drives the control unit: owns the fetch/decode/execute/mem stage counter, the program counter and
//  the 20-bit instruction register, and presents Instr_Stage + opCode to the control unit every cycle.

---
 rtl/urcpu_pkg.sv | 33 +++
 rtl/stage_sequencer_program_counter.sv | 27 ++
 rtl/stage_sequencer.sv | 121 ++++++++++++
 tb/tb_stage_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/urcpu_pkg.sv
// Shared definitions for the micro-CPU control path: stage codes, opcodes, sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package urcpu_pkg;

    // Stage code presented to the control unit on Instr_Stage
    localparam logic [1:0] STG_FETCH   = 2'b00;
    localparam logic [1:0] STG_DECODE  = 2'b01;
    localparam logic [1:0] STG_EXECUTE = 2'b10;
    localparam logic [1:0] STG_MEM     = 2'b11;

    // Opcodes; fetch/load/store share the all-zero encoding
    localparam logic [3:0] OP_FETCH = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0000;
    localparam logic [3:0] OP_JUMP  = 4'b0100;
    localparam logic [3:0] OP_ALU   = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        SEQ_FETCH,
        SEQ_DECODE,
        SEQ_EXECUTE,
        SEQ_MEM,
        SEQ_HALTED
    } seq_state_t;

    // Opcodes the sequencer carries through execute; everything else stops the machine
    function automatic logic op_is_defined(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_JUMP) || (op == OP_ALU);
    endfunction

endpackage

// File: rtl/stage_sequencer_program_counter.sv
// Program counter register with increment and parallel load; load has priority over increment.
// Latency: new value visible the cycle after inc/load.
// Backpressure: none; holds its value when neither enable is set.
module program_counter #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    // Jump target overrides the sequential increment; increment wraps naturally at 2^ADDR_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Fetch/decode/execute/mem sequencer: owns PC and IR, presents stage + opcode to the control unit.
// Latency: ack cycle + 3 cycles per instruction (4 cycles with zero-wait memory).
// Backpressure: FETCH waits indefinitely for mem_ack; with STAGE_SEQ_STEP_EN defined, MEM holds until step=1.
import urcpu_pkg::*;

module stage_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 20,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
`ifdef STAGE_SEQ_STEP_EN
    input  logic               step,
`endif
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [1:0]         Instr_Stage,
    output logic [3:0]         opCode,
    output logic [INSTR_W-5:0] operand,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    seq_state_t         state;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         ir_op;
    logic               fetch_done;
    logic               jump_now;
    logic               mem_step;

    assign ir_op      = ir[INSTR_W-1 -: 4];
    assign operand    = ir[INSTR_W-5:0];
    assign mem_addr   = pc;
    // ack only counts while a request is actually outstanding in FETCH
    assign fetch_done = (state == SEQ_FETCH) && mem_req && mem_ack;
    assign jump_now   = (state == SEQ_EXECUTE) && (ir_op == OP_JUMP);

`ifdef STAGE_SEQ_STEP_EN
    assign mem_step = step;
`else
    assign mem_step = 1'b1;
`endif

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .inc      (fetch_done),
        .load     (jump_now),
        .load_val (ir[ADDR_W-1:0]),
        .pc       (pc)
    );

    // Sequencer FSM with registered stage/opcode/request/halt outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEQ_FETCH;
            ir          <= '0;
            mem_req     <= 1'b0;
            Instr_Stage <= STG_FETCH;
            opCode      <= OP_FETCH;
            halted      <= 1'b0;
        end else begin
            case (state)
                SEQ_FETCH: begin
                    if (fetch_done) begin
                        ir          <= mem_rdata;
                        // loaded on the same edge as IR so DECODE already shows the IR opcode
                        opCode      <= mem_rdata[INSTR_W-1 -: 4];
                        mem_req     <= 1'b0;
                        Instr_Stage <= STG_DECODE;
                        state       <= SEQ_DECODE;
                    end else begin
                        // first FETCH after reset raises the request here
                        mem_req <= 1'b1;
                    end
                end
                SEQ_DECODE: begin
                    if (op_is_defined(ir_op)) begin
                        Instr_Stage <= STG_EXECUTE;
                        state       <= SEQ_EXECUTE;
                    end else begin
                        Instr_Stage <= STG_FETCH;
                        opCode      <= OP_HALT;
                        halted      <= 1'b1;
                        state       <= SEQ_HALTED;
                    end
                end
                SEQ_EXECUTE: begin
                    Instr_Stage <= STG_MEM;
                    state       <= SEQ_MEM;
                end
                SEQ_MEM: begin
                    if (mem_step) begin
                        // request issued on entry so a zero-wait ack completes in the first FETCH cycle
                        mem_req     <= 1'b1;
                        opCode      <= OP_FETCH;
                        Instr_Stage <= STG_FETCH;
                        state       <= SEQ_FETCH;
                    end
                end
                SEQ_HALTED: begin
                    mem_req <= 1'b0;
                end
                default: begin
                    mem_req     <= 1'b0;
                    Instr_Stage <= STG_FETCH;
                    opCode      <= OP_HALT;
                    halted      <= 1'b1;
                    state       <= SEQ_HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: expected stage traces queued per fetch, compared as the DUT walks them.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps

module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [19:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  Instr_Stage;
    logic [3:0]  opCode;
    logic [15:0] operand;
    logic [15:0] pc;
    logic        halted;
`ifdef STAGE_SEQ_STEP_EN
    logic        step;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  stg;
        logic [3:0]  op;
        logic [15:0] opnd;
        logic [15:0] pc;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    stage_sequencer dut (
        .clk         (clk),
        .rst         (rst),
`ifdef STAGE_SEQ_STEP_EN
        .step        (step),
`endif
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .Instr_Stage (Instr_Stage),
        .opCode      (opCode),
        .operand     (operand),
        .pc          (pc),
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Bounded wait (at negedges) for the fetch request
    task automatic wait_req();
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(mem_req), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        mem_ack = 1'b0;
        #1;
        check("rst_req",     32'(mem_req),     32'd0);
        check("rst_stage",   32'(Instr_Stage), 32'd0);
        check("rst_op",      32'(opCode),      32'd0);
        check("rst_operand", 32'(operand),     32'd0);
        check("rst_pc",      32'(pc),          32'd0);
        check("rst_halted",  32'(halted),      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("req_low_before_edge", 32'(mem_req), 32'd0);
        @(negedge clk);
    endtask

    // One instruction: optional wait states, ack, then walk the queued expected trace
    task automatic do_fetch(input logic [15:0] exp_addr, input logic [19:0] data,
                            input int waits, input bit hold_ack);
        exp_t        e;
        logic [3:0]  op;
        logic [15:0] pinc;
        logic [15:0] pnext;
        op    = data[19:16];
        pinc  = exp_addr + 16'd1;
        pnext = (op == 4'h4) ? data[15:0] : pinc;
        wait_req();
        check("fetch_addr",  32'(mem_addr),    32'(exp_addr));
        check("fetch_stage", 32'(Instr_Stage), 32'd0);
        check("fetch_op",    32'(opCode),      32'd0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("wait_req",   32'(mem_req),     32'd1);
            check("wait_addr",  32'(mem_addr),    32'(exp_addr));
            check("wait_stage", 32'(Instr_Stage), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        exp_q.push_back('{stg: 2'b01, op: op, opnd: data[15:0], pc: pinc, hlt: 1'b0});
        if (op == 4'h0 || op == 4'h4 || op == 4'h6) begin
            exp_q.push_back('{stg: 2'b10, op: op, opnd: data[15:0], pc: pinc,  hlt: 1'b0});
            exp_q.push_back('{stg: 2'b11, op: op, opnd: data[15:0], pc: pnext, hlt: 1'b0});
        end else begin
            exp_q.push_back('{stg: 2'b00, op: 4'hF, opnd: data[15:0], pc: pinc, hlt: 1'b1});
        end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check("stage",   32'(Instr_Stage), 32'(e.stg));
            check("opcode",  32'(opCode),      32'(e.op));
            check("operand", 32'(operand),     32'(e.opnd));
            check("pc",      32'(pc),          32'(e.pc));
            check("halted",  32'(halted),      32'(e.hlt));
            check("req_off", 32'(mem_req),     32'd0);
            if (hold_ack && exp_q.size() > 0) begin
                // stray ack with a different word must not be captured outside FETCH
                mem_rdata = 20'hF0000;
            end else begin
                mem_ack = 1'b0;
            end
        end
    endtask

    task automatic check_halted(input int cycles, input logic [15:0] exp_pc);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("hlt_flag",  32'(halted),      32'd1);
            check("hlt_req",   32'(mem_req),     32'd0);
            check("hlt_op",    32'(opCode),      32'hF);
            check("hlt_stage", 32'(Instr_Stage), 32'd0);
            check("hlt_pc",    32'(pc),          32'(exp_pc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
`ifdef STAGE_SEQ_STEP_EN
        step      = 1'b1;
`endif
        do_reset();

        // zero-wait ALU instruction: stages 00,01,10,11, opcode 0,6,6,6, pc 0->1
        do_fetch(16'h0000, 20'h60012, 0, 1'b0);
        // jump to 5 with ack held high through decode/execute/mem
        do_fetch(16'h0001, 20'h40005, 0, 1'b1);
        // jump from 5 to 0x0ABC
        do_fetch(16'h0005, 20'h40ABC, 0, 1'b0);
        // load with 3 wait states at the jump target
        do_fetch(16'h0ABC, 20'h0FFFF, 3, 1'b0);
        // jump to the top of the address space
        do_fetch(16'h0ABD, 20'h4FFFF, 0, 1'b0);
        // non-jump at 0xFFFF wraps PC to 0
        do_fetch(16'hFFFF, 20'h01234, 0, 1'b0);
        // HALT stops the machine for good
        do_fetch(16'h0000, 20'hF0000, 0, 1'b0);
        check_halted(5, 16'h0001);

        // undefined opcode also halts
        do_reset();
        do_fetch(16'h0000, 20'h30000, 1, 1'b0);
        check_halted(4, 16'h0001);

        // reset asserted while a fetch is pending drops the request without a clock edge
        do_reset();
        wait_req();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req",   32'(mem_req),     32'd0);
        check("midrst_stage", 32'(Instr_Stage), 32'd0);
        check("midrst_pc",    32'(pc),          32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_fetch(16'h0000, 20'h60012, 0, 1'b0);

`ifdef STAGE_SEQ_STEP_EN
        // MEM holds while step is low, then advances on the step pulse
        step = 1'b0;
        do_fetch(16'h0001, 20'h00000, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("step_hold_stage", 32'(Instr_Stage), 32'd3);
            check("step_hold_req",   32'(mem_req),     32'd0);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("step_go_stage", 32'(Instr_Stage), 32'd0);
        check("step_go_req",   32'(mem_req),     32'd1);
        check("step_go_addr",  32'(mem_addr),    32'd2);
        step = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
